modexp_share_ctrl: RTL and testbench

Sequencer and arbiter that shares the single `modexp1` modular-exponentiation engine between two requesters: port 0 for encryption and port 1 for decryption. It accepts one job at a time and latches the operands. It starts the engine with a one-cycle pulse, waits for completion, and returns the result with a one-cycle valid to the requester that owns the job. It sits between the encryptor/decryptor front ends and the shared engine instance.

---
 rtl/modexp_ctrl_pkg.sv | 20 ++
 rtl/modexp_share_ctrl_rr_pick2.sv | 21 ++
 rtl/modexp_share_ctrl.sv | 175 +++++++++++++++++
 tb/tb_modexp_share_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_ctrl_pkg.sv
// Shared types and constants for the modexp engine sharing controller.
package modexp_ctrl_pkg;

    localparam int W_DEFAULT = 64;

    localparam logic REQ_ENC = 1'b0;
    localparam logic REQ_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        idx_to_onehot = (idx == REQ_DEC) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/modexp_share_ctrl_rr_pick2.sv
// Combinational two-way round-robin picker; 'last' is the index of the previous owner.
module rr_pick2
    import modexp_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    // On contention the requester that did not own the last job wins.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = (last == REQ_DEC) ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/modexp_share_ctrl.sv
// Sequencer/arbiter sharing one modexp engine between an encrypt and a decrypt port.
// Optional watchdog abort enabled by defining MODEXP_WDOG_EN.
module modexp_share_ctrl
    import modexp_ctrl_pkg::*;
#(
    parameter int W              = W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 65535
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] base0,
    input  logic [W-1:0] exp0,
    input  logic [W-1:0] mod0,
    input  logic [W-1:0] base1,
    input  logic [W-1:0] exp1,
    input  logic [W-1:0] mod1,
    output logic [1:0]   gnt,
    output logic [1:0]   rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic         busy,
    output logic [W-1:0] eng_base,
    output logic [W-1:0] eng_exponent,
    output logic [W-1:0] eng_modulus,
    output logic         eng_start,
    input  logic [W-1:0] eng_result,
    input  logic         eng_done,
    output logic         eng_clr
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_RESP  = ST_RESP;

    logic [1:0]   r_state;
    logic         r_owner;
    logic         r_last;
    logic [1:0]   r_gnt;
    logic [1:0]   r_rsp_valid;
    logic [W-1:0] r_rsp_data;
    logic         r_rsp_err;
    logic         r_busy;
    logic         r_eng_start;
    logic [W-1:0] r_eng_base;
    logic [W-1:0] r_eng_exp;
    logic [W-1:0] r_eng_mod;

    logic [1:0]   w_pick;
    logic         w_win;
    logic [W-1:0] w_sel_base;
    logic [W-1:0] w_sel_exp;
    logic [W-1:0] w_sel_mod;

    rr_pick2 u_pick (
        .req  (req),
        .last (r_last),
        .pick (w_pick)
    );

    assign w_win      = w_pick[1];
    assign w_sel_base = (w_win == REQ_DEC) ? base1 : base0;
    assign w_sel_exp  = (w_win == REQ_DEC) ? exp1  : exp0;
    assign w_sel_mod  = (w_win == REQ_DEC) ? mod1  : mod0;

`ifdef MODEXP_WDOG_EN
    logic [31:0] r_wdog;
    logic        r_eng_clr;
    assign eng_clr = r_eng_clr;
`else
    // The timeout parameter only matters when the watchdog is built.
    logic w_unused_cfg;
    assign w_unused_cfg = ^(32'(TIMEOUT_CYCLES));
    assign eng_clr      = 1'b0;
`endif

    // Job sequencer: arbitration, operand latching, engine handshake and response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner     <= REQ_ENC;
            r_last      <= REQ_DEC;
            r_gnt       <= 2'b00;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= {W{1'b0}};
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_eng_start <= 1'b0;
            r_eng_base  <= {W{1'b0}};
            r_eng_exp   <= {W{1'b0}};
            r_eng_mod   <= {W{1'b0}};
`ifdef MODEXP_WDOG_EN
            r_wdog      <= 32'd0;
            r_eng_clr   <= 1'b0;
`endif
        end else begin
            r_gnt       <= 2'b00;
            r_rsp_valid <= 2'b00;
            r_eng_start <= 1'b0;
`ifdef MODEXP_WDOG_EN
            r_eng_clr   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_pick != 2'b00) begin
                        r_owner    <= w_win;
                        r_eng_base <= w_sel_base;
                        r_eng_exp  <= w_sel_exp;
                        r_eng_mod  <= w_sel_mod;
                        r_gnt      <= w_pick;
                        r_busy     <= 1'b1;
                        // A zero modulus is answered immediately and never reaches the engine.
                        if (w_sel_mod == {W{1'b0}}) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= w_pick;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= {W{1'b0}};
                        end else begin
                            r_state     <= S_ISSUE;
                            r_eng_start <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
`ifdef MODEXP_WDOG_EN
                    r_wdog  <= 32'd0;
`endif
                end
                S_WAIT: begin
                    if (eng_done) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= idx_to_onehot(r_owner);
                        r_rsp_data  <= eng_result;
                        r_rsp_err   <= 1'b0;
`ifdef MODEXP_WDOG_EN
                    end else if (r_wdog == 32'(TIMEOUT_CYCLES - 1)) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= idx_to_onehot(r_owner);
                        r_rsp_data  <= {W{1'b0}};
                        r_rsp_err   <= 1'b1;
                        r_eng_clr   <= 1'b1;
                    end else begin
                        r_wdog      <= r_wdog + 32'd1;
`endif
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign busy         = r_busy;
    assign eng_start    = r_eng_start;
    assign eng_base     = r_eng_base;
    assign eng_exponent = r_eng_exp;
    assign eng_modulus  = r_eng_mod;

endmodule

// File: tb/tb_modexp_share_ctrl.sv
// Self-checking bench for modexp_share_ctrl: vector table, scoreboard and corner-case sequences.
module tb_modexp_share_ctrl;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] base0, exp0, mod0, base1, exp1, mod1;
    logic [1:0]   gnt, rsp_valid;
    logic [W-1:0] rsp_data;
    logic         rsp_err, busy, eng_start, eng_done, eng_clr;
    logic [W-1:0] eng_base, eng_exponent, eng_modulus, eng_result;

    always #5 clk = ~clk;

    modexp_share_ctrl #(.W(W), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .req(req),
        .base0(base0), .exp0(exp0), .mod0(mod0),
        .base1(base1), .exp1(exp1), .mod1(mod1),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .eng_base(eng_base), .eng_exponent(eng_exponent),
        .eng_modulus(eng_modulus), .eng_start(eng_start), .eng_result(eng_result),
        .eng_done(eng_done), .eng_clr(eng_clr)
    );

    typedef struct {
        logic [1:0]  req;
        logic [63:0] b, e, m;
        int          delay;
        logic [1:0]  exp_gnt;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [1:0]  valid;
        logic [63:0] data;
        logic        err;
    } rsp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_gnt    = 0;
    int   n_start  = 0;
    int   n_clr    = 0;
    int   rsp_cnt  = 0;
    rsp_t sb_q[$];

    int          eng_delay   = 1;
    logic        eng_hang    = 1'b0;
    logic        inject_done = 1'b0;
    int          eng_cnt     = 0;
    logic [63:0] pend_res    = 64'd0;

    function automatic logic [63:0] modexp_ref(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m);
        logic [127:0] r, bb, mm;
        logic [63:0]  ee;
        if (m == 64'd0) return 64'd0;
        mm = {64'd0, m};
        r  = 128'd1 % mm;
        bb = {64'd0, b} % mm;
        ee = e;
        while (ee != 64'd0) begin
            if (ee[0]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
            ee = ee >> 1;
        end
        return r[63:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        else n_pass++;
    endtask

    // Engine model: computes the result when started and answers eng_delay cycles later.
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (!rst) begin
            eng_cnt = 0;
        end else if (eng_start) begin
            eng_cnt  = eng_delay;
            pend_res = modexp_ref(eng_base, eng_exponent, eng_modulus);
        end else if (eng_cnt != 0) begin
            eng_cnt--;
            if (eng_cnt == 0 && !eng_hang) begin
                eng_done   = 1'b1;
                eng_result = pend_res;
            end
        end
        if (inject_done) begin
            eng_done    = 1'b1;
            inject_done = 1'b0;
        end
    end

    // Output monitor: event counters and scoreboard comparison of every response.
    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            if (gnt != 2'b00) n_gnt++;
            if (eng_start) n_start++;
            if (eng_clr) n_clr++;
            if (rsp_valid != 2'b00) begin
                rsp_cnt++;
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_owner", {62'd0, rsp_valid}, {62'd0, e.valid});
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                end
            end
        end
    end

    task automatic wait_rsp(input int target);
        for (int k = 0; k < 200; k++) begin
            if (rsp_cnt >= target) return;
            @(negedge clk);
        end
        check("rsp_timeout", rsp_cnt, target);
    endtask

    task automatic run_vec(input vec_t v);
        int s0, r0;
        s0 = n_start;
        r0 = rsp_cnt;
        eng_delay = v.delay;
        if (v.req[0]) begin base0 = v.b; exp0 = v.e; mod0 = v.m; end
        else begin base0 = 64'd9; exp0 = 64'd9; mod0 = 64'd999; end
        if (v.req[1]) begin base1 = v.b; exp1 = v.e; mod1 = v.m; end
        else begin base1 = 64'd8; exp1 = 64'd8; mod1 = 64'd998; end
        req = v.req;
        sb_q.push_back('{valid: v.exp_gnt, data: v.exp_data, err: v.exp_err});
        @(negedge clk);
        check("vec_gnt", {62'd0, gnt}, {62'd0, v.exp_gnt});
        check("vec_start", {63'd0, eng_start}, {63'd0, !v.exp_err});
        check("vec_busy", {63'd0, busy}, 64'd1);
        check("vec_eng_base", eng_base, v.b);
        check("vec_eng_exp", eng_exponent, v.e);
        check("vec_eng_mod", eng_modulus, v.m);
        if (v.exp_err) check("vec_rej_valid", {62'd0, rsp_valid}, {62'd0, v.exp_gnt});
        req = 2'b00;
        wait_rsp(r0 + 1);
        @(negedge clk);
        check("vec_idle", {63'd0, busy}, 64'd0);
        check("vec_nstart", n_start - s0, v.exp_err ? 64'd0 : 64'd1);
    endtask

    initial begin
        vec_t vecs[6];
        int   ng, last_k, g0, r0, lat;

        vecs[0] = '{req: 2'b01, b: 64'd4, e: 64'd13, m: 64'd497, delay: 10, exp_gnt: 2'b01, exp_data: 64'd445, exp_err: 1'b0};
        vecs[1] = '{req: 2'b10, b: 64'd7, e: 64'd5, m: 64'd1000, delay: 3, exp_gnt: 2'b10, exp_data: 64'd807, exp_err: 1'b0};
        vecs[2] = '{req: 2'b10, b: 64'd5, e: 64'd3, m: 64'd0, delay: 3, exp_gnt: 2'b10, exp_data: 64'd0, exp_err: 1'b1};
        vecs[3] = '{req: 2'b01, b: 64'd6, e: 64'd2, m: 64'd0, delay: 3, exp_gnt: 2'b01, exp_data: 64'd0, exp_err: 1'b1};
        vecs[4] = '{req: 2'b01, b: 64'd123456789, e: 64'd65537, m: 64'd1000003, delay: 1, exp_gnt: 2'b01,
                    exp_data: modexp_ref(64'd123456789, 64'd65537, 64'd1000003), exp_err: 1'b0};
        vecs[5] = '{req: 2'b10, b: 64'd2, e: 64'd0, m: 64'd7, delay: 2, exp_gnt: 2'b10, exp_data: 64'd1, exp_err: 1'b0};

        rst = 1'b0; req = 2'b00; eng_result = 64'd0;
        base0 = 64'd0; exp0 = 64'd0; mod0 = 64'd0; base1 = 64'd0; exp1 = 64'd0; mod1 = 64'd0;
        repeat (3) @(negedge clk);
        check("reset_gnt", {62'd0, gnt}, 64'd0);
        check("reset_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_start", {63'd0, eng_start}, 64'd0);
        check("reset_rsp_data", rsp_data, 64'd0);
        check("reset_eng_mod", eng_modulus, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Contention: both held, grants alternate exactly 4 cycles apart with a 1-cycle engine.
        r0 = rsp_cnt; eng_delay = 1;
        base0 = 64'd3; exp0 = 64'd4; mod0 = 64'd11;
        base1 = 64'd5; exp1 = 64'd3; mod1 = 64'd13;
        for (int j = 0; j < 4; j++)
            sb_q.push_back('{valid: (j % 2 == 0) ? 2'b01 : 2'b10, data: (j % 2 == 0) ? 64'd4 : 64'd8, err: 1'b0});
        req = 2'b11; ng = 0; last_k = 0;
        for (int k = 0; k < 200 && ng < 4; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                check("cont_gnt", {62'd0, gnt}, (ng % 2 == 0) ? 64'd1 : 64'd2);
                if (ng > 0) check("cont_spacing", k - last_k, 64'd4);
                last_k = k;
                ng++;
                if (ng == 4) req = 2'b00;
            end
        end
        check("cont_ngnt", ng, 64'd4);
        wait_rsp(r0 + 4);
        repeat (2) @(negedge clk);

        // Withdrawn request while busy, then a spurious done in IDLE.
        g0 = n_gnt; r0 = rsp_cnt; eng_delay = 8;
        base0 = 64'd2; exp0 = 64'd10; mod0 = 64'd1000;
        sb_q.push_back('{valid: 2'b01, data: 64'd24, err: 1'b0});
        req = 2'b01;
        @(negedge clk);
        check("wd_gnt", {62'd0, gnt}, 64'd1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        wait_rsp(r0 + 1);
        repeat (10) @(negedge clk);
        check("wd_no_regrant", n_gnt - g0, 64'd1);
        inject_done = 1'b1;
        repeat (5) @(negedge clk);
        check("spur_no_rsp", rsp_cnt, r0 + 1);
        check("spur_idle", {63'd0, busy}, 64'd0);

        // Reset in WAIT: outputs clear at once, no response, pointer back to requester 0.
        r0 = rsp_cnt; eng_delay = 20;
        base0 = 64'd6; exp0 = 64'd2; mod0 = 64'd100;
        sb_q.push_back('{valid: 2'b01, data: 64'd36, err: 1'b0});
        req = 2'b01;
        @(negedge clk);
        check("rst_job_start", {63'd0, eng_start}, 64'd1);
        req = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_eng_base", eng_base, 64'd0);
        check("rst_eng_mod", eng_modulus, 64'd0);
        check("rst_gnt", {62'd0, gnt}, 64'd0);
        check("rst_clr", {63'd0, eng_clr}, 64'd0);
        repeat (2) @(negedge clk);
        sb_q.delete();
        check("rst_no_rsp", rsp_cnt, r0);
        rst = 1'b1;
        @(negedge clk);
        eng_delay = 3;
        base1 = 64'd5; exp1 = 64'd3; mod1 = 64'd13;
        sb_q.push_back('{valid: 2'b01, data: 64'd36, err: 1'b0});
        req = 2'b11;
        @(negedge clk);
        check("post_rst_rr", {62'd0, gnt}, 64'd1);
        req = 2'b00;
        wait_rsp(r0 + 1);
        repeat (2) @(negedge clk);

`ifdef MODEXP_WDOG_EN
        // Hung engine: abort after 20 WAIT cycles with an error response.
        r0 = rsp_cnt; eng_hang = 1'b1; eng_delay = 5;
        base0 = 64'd2; exp0 = 64'd3; mod0 = 64'd5;
        sb_q.push_back('{valid: 2'b01, data: 64'd0, err: 1'b1});
        req = 2'b01;
        @(negedge clk);
        check("wdog_gnt", {62'd0, gnt}, 64'd1);
        req = 2'b00;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (eng_clr) begin
                lat = k;
                check("wdog_rsp_with_clr", {62'd0, rsp_valid}, 64'd1);
                break;
            end
        end
        check("wdog_latency", lat, 64'd21);
        wait_rsp(r0 + 1);
        eng_hang = 1'b0;
        repeat (2) @(negedge clk);
        check("wdog_nclr", n_clr, 64'd1);
`else
        lat = 0;
        check("no_wdog_clr", n_clr + lat, 64'd0);
`endif

        check("sb_empty", sb_q.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
